// File: rtl/stream_pkg.sv
// stream_pkg: shared constants, types and helpers for the stream demultiplexer
package stream_pkg;

    localparam int N_OUT_MIN = 2;
    localparam int N_OUT_MAX = 16;

    // Shifted left by the select index to form the one-hot destination valid
    localparam logic [N_OUT_MAX-1:0] ONE_HOT_LSB = 16'h0001;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    // Select width for n destinations, never below 1 bit
    function automatic int clog2(input int n);
        int w;
        for (w = 1; (1 << w) < n; w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/demux_stream_if.sv
// demux_stream_if: producer-side and consumer-side stream signals of the demultiplexer
interface demux_stream_if
    import stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 2,
    parameter int SEL_W  = clog2(N_OUT)
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_sel;
    logic [N_OUT-1:0]  out_valid;
    logic [N_OUT-1:0]  out_ready;
    logic [DATA_W-1:0] out_data;
    logic              err_drop;

    // Environment side: drives the input beat and the destination readies
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, err_drop
    );

    // Demultiplexer side
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, err_drop
    );
endinterface

// File: rtl/demux_skid_buf.sv
// demux_skid_buf: 1-entry skid register that turns upstream ready into a flop output
module demux_skid_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);
    logic         full_q;
    logic [W-1:0] data_q;

    // Park the beat that arrived while downstream stalled; release it once downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (!full_q && s_valid && !m_ready) begin
            full_q <= 1'b1;
            data_q <= s_data;
        end else if (full_q && m_ready) begin
            full_q <= 1'b0;
        end
    end

    assign s_ready = !full_q;
    assign m_valid = full_q | s_valid;
    assign m_data  = full_q ? data_q : s_data;
endmodule

// File: rtl/demux_stream.sv
// demux_stream: 1-to-N valid/ready demultiplexer with a registered output stage.
// Define DEMUX_SKID_EN to insert a skid register so in_ready comes from a flop.
module demux_stream
    import stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 2,
    parameter int SEL_W  = clog2(N_OUT)
) (
    input logic            clk,
    input logic            rst_n,
    demux_stream_if.slave  bus
);
    localparam int BEAT_W = DATA_W + SEL_W;

    logic              st_valid;
    logic              st_ready;
    logic [DATA_W-1:0] st_data;
    logic [SEL_W-1:0]  st_sel;

`ifdef DEMUX_SKID_EN
    logic [BEAT_W-1:0] st_beat;

    demux_skid_buf #(.W(BEAT_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (bus.in_valid),
        .s_ready (bus.in_ready),
        .s_data  ({bus.in_data, bus.in_sel}),
        .m_valid (st_valid),
        .m_ready (st_ready),
        .m_data  (st_beat)
    );

    assign st_data = st_beat[BEAT_W-1:SEL_W];
    assign st_sel  = st_beat[SEL_W-1:0];
`else
    assign st_valid     = bus.in_valid;
    assign st_data      = bus.in_data;
    assign st_sel       = bus.in_sel;
    assign bus.in_ready = st_ready;
`endif

    stage_state_e      state_q;
    stage_state_e      state_d;
    logic [DATA_W-1:0] data_q;
    logic [SEL_W-1:0]  sel_q;
    logic              err_q;
    logic              sel_ready;
    logic              in_range;
    logic              accept;
    logic              load;
    logic              drain;
    logic [N_OUT-1:0]  out_valid_c;

    // Out-of-range selects only exist when N_OUT is not a power of two
    assign in_range = {1'b0, st_sel} < (SEL_W + 1)'(N_OUT);
    assign accept   = st_valid & st_ready;
    assign load     = accept & in_range;
    assign drain    = (state_q == ST_FULL) & sel_ready;

    // Ready of the destination the held beat is addressed to; other readies are ignored
    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < N_OUT; i++)
            if (sel_q == SEL_W'(i)) sel_ready = bus.out_ready[i];
    end

    // Stage occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // A load wins over a drain so a beat can enter on the same edge the held one leaves
    always_comb begin
        state_d = load ? ST_FULL : (drain ? ST_EMPTY : state_q);
    end

    // Handshake outputs: accept when empty or when the held beat drains this cycle
    always_comb begin
        st_ready    = (state_q == ST_EMPTY) | sel_ready;
        out_valid_c = (state_q == ST_FULL) ? N_OUT'(ONE_HOT_LSB << sel_q) : '0;
    end

    // Payload capture and drop flag; a dropped beat leaves the stage untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= accept & !in_range;
            if (load) begin
                data_q <= st_data;
                sel_q  <= st_sel;
            end
        end
    end

    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = data_q;
    assign bus.err_drop  = err_q;
endmodule
